// File: rtl/cpu_mem_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: owns PC/IR and time-shares one
// byte-wide memory port between two-byte instruction fetch and data load/store.
module cpu_mem_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  dp_addr,
    input  logic [7:0]  dp_data,
    input  logic        dp_z,
    input  logic        dp_n,
    output logic [15:0] ir,
    output logic [7:0]  pc,
    output logic [7:0]  ld_data,
    output logic        rw_en,
    output logic        instr_done,
    output logic [2:0]  state
);

    // Memory handshake: a transfer completes on the rising edge where mem_req and
    // mem_ack are both 1; mem_addr/mem_we/mem_wdata are registered and held while
    // mem_req is high, and mem_req always drops for at least one cycle in between.
    typedef enum logic [2:0] {
        FETCH_HI = 3'd0,
        FETCH_LO = 3'd1,
        EXEC     = 3'd2,
        MEM      = 3'd3,
        WB       = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  ld_data_q, ld_data_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        is_pl, is_st, is_ld, xfer, br_taken;
    logic [7:0]  br_off, pc_plus2;

    assign is_pl    = ir_q[15] & ir_q[14];
    assign is_st    = ~ir_q[15] & ir_q[14];
    assign is_ld    = ~ir_q[15] & ~ir_q[14] & ir_q[13];
    assign xfer     = req_q & mem_ack;
    assign pc_plus2 = pc_q + 8'd2;
    // Sign-extended 6-bit word offset, scaled to bytes.
    assign br_off   = {ir_q[8], ir_q[8:6], ir_q[2:0], 1'b0};
    assign br_taken = ir_q[9] ? dp_n : dp_z;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ld_data_d  = ld_data_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_en      = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH_HI: begin
                if (req_q) begin
                    if (mem_ack) begin
                        ir_d[15:8] = mem_rdata;
                        req_d      = 1'b0;
                        state_d    = FETCH_LO;
                    end
                end else begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end
            end
            FETCH_LO: begin
                if (req_q) begin
                    if (mem_ack) begin
                        ir_d[7:0] = mem_rdata;
                        req_d     = 1'b0;
                        state_d   = EXEC;
                    end
                end else begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q + 8'd1;
                end
            end
            EXEC: begin
                if (is_pl) begin
                    instr_done = 1'b1;
                    state_d    = FETCH_HI;
                    if (ir_q[13])      pc_d = dp_addr & 8'hFE;
                    else if (br_taken) pc_d = pc_q + br_off;
                    else               pc_d = pc_plus2;
                end else if (is_ld || is_st) begin
                    req_d   = 1'b1;
                    we_d    = is_st;
                    addr_d  = dp_addr;
                    wdata_d = dp_data;
                    state_d = MEM;
                end else begin
                    rw_en      = 1'b1;
                    instr_done = 1'b1;
                    pc_d       = pc_plus2;
                    state_d    = FETCH_HI;
                end
            end
            MEM: begin
                if (xfer) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (we_q) begin
                        instr_done = 1'b1;
                        pc_d       = pc_plus2;
                        state_d    = FETCH_HI;
                    end else begin
                        ld_data_d = mem_rdata;
                        state_d   = WB;
                    end
                end
            end
            WB: begin
                rw_en      = 1'b1;
                instr_done = 1'b1;
                pc_d       = pc_plus2;
                state_d    = FETCH_HI;
            end
            default: begin
                state_d = FETCH_HI;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_HI;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            ld_data_q <= 8'h00;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ld_data_q <= ld_data_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign ld_data   = ld_data_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed bench for cpu_mem_sequencer: byte memory model with programmable ack delay,
// expected bus transfers and retirements queued by the driver, checked by a monitor.
module tb_cpu_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, rw_en, instr_done;
    logic [7:0]  mem_addr, mem_wdata, pc, ld_data;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  dp_addr = 8'h00, dp_data = 8'h00;
    logic        dp_z = 1'b0, dp_n = 1'b0;
    logic [15:0] ir;
    logic [2:0]  state;

    cpu_mem_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dp_addr(dp_addr), .dp_data(dp_data), .dp_z(dp_z), .dp_n(dp_n),
        .ir(ir), .pc(pc), .ld_data(ld_data), .rw_en(rw_en), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // bus entry: {we, addr, wdata, ir seen at the ack}
    logic [32:0] bus_exp_q[$];
    // retire entry: {ir, rw_en, ld_data, latency, next pc}
    logic [40:0] ret_exp_q[$];

    logic [7:0] mem [256];
    int ack_delay = 0;
    int wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [7:0] a, input logic [15:0] ir_now);
        bus_exp_q.push_back({1'b0, a, 8'h00, ir_now});
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input logic [15:0] ir_now);
        bus_exp_q.push_back({1'b1, a, d, ir_now});
    endtask

    task automatic exp_ret(input logic [15:0] i, input logic rw, input logic [7:0] ld,
                           input logic [7:0] lat, input logic [7:0] npc);
        ret_exp_q.push_back({i, rw, ld, lat, npc});
    endtask

    // Memory model: decides ack shortly after each rising edge, so it is stable at the next one.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt  = 0;
                if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
                wait_cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            wait_cnt  = 0;
        end
    end

    // Monitor
    int          lat = 0;
    logic        pc_pending = 1'b0;
    logic [7:0]  npc_exp = 8'h00;
    logic        prev_wait = 1'b0;
    logic [16:0] prev_bus = '0;

    always @(negedge clk) begin
        logic [32:0] be;
        logic [40:0] re;
        if (pc_pending) begin
            check("pc_after_retire", {24'h0, pc}, {24'h0, npc_exp});
            pc_pending = 1'b0;
        end
        if (reset) begin
            lat       = 0;
            prev_wait = 1'b0;
        end else begin
            lat++;
            if (mem_req && prev_wait)
                check("bus_stable_in_wait", {15'h0, mem_we, mem_addr, mem_wdata}, {15'h0, prev_bus});
            prev_wait = mem_req && !mem_ack;
            prev_bus  = {mem_we, mem_addr, mem_wdata};
            if (state == 3'd0 || state == 3'd1 || state == 3'd3)
                check("rw_en_idle", {31'h0, rw_en}, 32'h0);
            if (state == 3'd0 || state == 3'd1)
                check("instr_done_fetch", {31'h0, instr_done}, 32'h0);
            if (mem_req && mem_ack) begin
                if (bus_exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bus_unexpected: got addr %0h we %0b expected none", mem_addr, mem_we);
                end else begin
                    be = bus_exp_q.pop_front();
                    check("bus_we", {31'h0, mem_we}, {31'h0, be[32]});
                    check("bus_addr", {24'h0, mem_addr}, {24'h0, be[31:24]});
                    if (be[32]) check("bus_wdata", {24'h0, mem_wdata}, {24'h0, be[23:16]});
                    check("ir_at_ack", {16'h0, ir}, {16'h0, be[15:0]});
                end
            end
            if (instr_done) begin
                if (ret_exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL retire_unexpected: got ir %0h expected none", ir);
                end else begin
                    re = ret_exp_q.pop_front();
                    check("retire_ir", {16'h0, ir}, {16'h0, re[40:25]});
                    check("retire_rw_en", {31'h0, rw_en}, {31'h0, re[24]});
                    check("retire_ld_data", {24'h0, ld_data}, {24'h0, re[23:16]});
                    check("retire_latency", lat, {24'h0, re[15:8]});
                    npc_exp    = re[7:0];
                    pc_pending = 1'b1;
                end
                lat = 0;
            end
        end
    end

    // Driver
    task automatic prep(input int dly);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ack_delay = dly;
        dp_addr = 8'h00; dp_data = 8'h00; dp_z = 1'b0; dp_n = 1'b0;
    endtask

    task automatic run(input int n_ret, input int budget);
        int seen = 0;
        int cyc = 0;
        @(posedge clk); #1 reset = 1'b0;
        while (seen < n_ret && cyc < budget) begin
            @(negedge clk);
            if (instr_done) seen++;
            cyc++;
        end
        if (seen < n_ret) begin
            n_cmp++; n_err++;
            $display("FAIL retire_timeout: got %0d retires expected %0d", seen, n_ret);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #2;
        check("bus_queue_drained", bus_exp_q.size(), 32'd0);
        check("retire_queue_drained", ret_exp_q.size(), 32'd0);
        bus_exp_q.delete();
        ret_exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_ir", {16'h0, ir}, 32'h0);
        check("rst_ld_data", {24'h0, ld_data}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        check("rst_rw_en", {31'h0, rw_en}, 32'h0);
        check("rst_instr_done", {31'h0, instr_done}, 32'h0);
        check("rst_state", {29'h0, state}, 32'h0);

        // ALU, zero-wait
        prep(0);
        mem[8'h00] = 8'h04; mem[8'h01] = 8'h4A;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'h0400);
        exp_ret(16'h044A, 1'b1, 8'h00, 8'd5, 8'h02);
        run(1, 40);

        // ALU, three wait cycles per fetch
        prep(3);
        mem[8'h00] = 8'h04; mem[8'h01] = 8'h4A;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'h0400);
        exp_ret(16'h044A, 1'b1, 8'h00, 8'd11, 8'h02);
        run(1, 60);

        // Load from 80
        prep(0);
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h00; mem[8'h80] = 8'h5C;
        dp_addr = 8'h80;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'h2000); exp_rd(8'h80, 16'h2000);
        exp_ret(16'h2000, 1'b1, 8'h5C, 8'd7, 8'h02);
        run(1, 40);

        // Store A5 to 90
        prep(0);
        mem[8'h00] = 8'h40; mem[8'h01] = 8'h00;
        dp_addr = 8'h90; dp_data = 8'hA5;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'h4000); exp_wr(8'h90, 8'hA5, 16'h4000);
        exp_ret(16'h4000, 1'b0, 8'h00, 8'd6, 8'h02);
        run(1, 40);
        check("store_mem_90", {24'h0, mem[8'h90]}, 32'hA5);

        // JMP to 11 (-> 10), BRZ -2 words taken -> 0C
        prep(0);
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h00; mem[8'h10] = 8'hC1; mem[8'h11] = 8'hC6;
        dp_addr = 8'h11; dp_z = 1'b1;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'hE000);
        exp_rd(8'h10, 16'hE000); exp_rd(8'h11, 16'hC100);
        exp_ret(16'hE000, 1'b0, 8'h00, 8'd5, 8'h10);
        exp_ret(16'hC1C6, 1'b0, 8'h00, 8'd5, 8'h0C);
        run(2, 40);

        // Same BRZ not taken -> 12
        prep(0);
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h00; mem[8'h10] = 8'hC1; mem[8'h11] = 8'hC6;
        dp_addr = 8'h10; dp_z = 1'b0; dp_n = 1'b1;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'hE000);
        exp_rd(8'h10, 16'hE000); exp_rd(8'h11, 16'hC100);
        exp_ret(16'hE000, 1'b0, 8'h00, 8'd5, 8'h10);
        exp_ret(16'hC1C6, 1'b0, 8'h00, 8'd5, 8'h12);
        run(2, 40);

        // JMP to 33 (-> 32), BRN +3 words taken -> 38
        prep(0);
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h00; mem[8'h32] = 8'hC2; mem[8'h33] = 8'h03;
        dp_addr = 8'h33; dp_z = 1'b0; dp_n = 1'b1;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'hE000);
        exp_rd(8'h32, 16'hE000); exp_rd(8'h33, 16'hC200);
        exp_ret(16'hE000, 1'b0, 8'h00, 8'd5, 8'h32);
        exp_ret(16'hC203, 1'b0, 8'h00, 8'd5, 8'h38);
        run(2, 40);

        // JMP to FE, ALU at FE wraps pc to 00
        prep(0);
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h00; mem[8'hFE] = 8'h04; mem[8'hFF] = 8'h4A;
        dp_addr = 8'hFF;
        exp_rd(8'h00, 16'h0000); exp_rd(8'h01, 16'hE000);
        exp_rd(8'hFE, 16'hE000); exp_rd(8'hFF, 16'h0400);
        exp_ret(16'hE000, 1'b0, 8'h00, 8'd5, 8'hFE);
        exp_ret(16'h044A, 1'b1, 8'h00, 8'd5, 8'h00);
        run(2, 40);

        // Reset landing on a cycle with mem_req=1 and mem_ack=1
        prep(0);
        mem[8'h00] = 8'h04; mem[8'h01] = 8'h4A;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
        check("pre_rst_mem_ack", {31'h0, mem_ack}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        check("midrst_pc", {24'h0, pc}, 32'h0);
        check("midrst_ir", {16'h0, ir}, 32'h0);
        check("midrst_state", {29'h0, state}, 32'h0);
        check("midrst_rw_en", {31'h0, rw_en}, 32'h0);
        repeat (2) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_mem_sequencer.md
Name: cpu_mem_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit CPU datapath.
- Owns PC and IR and shares a single byte-wide unified memory port between instruction fetch (two bytes per 16-bit instruction) and data load/store.
- Generates one-cycle register-write strobes for the datapath and resolves branches and jumps from datapath status.
- Sits between the datapath (register file/function unit) and the memory subsystem.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset; bit 0 must be 0.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  8  byte address; valid while mem_req
- mem_wdata  out  8  store data; valid while mem_req & mem_we
- mem_rdata  in  8  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  transfer completes on the rising edge where mem_req=1 and mem_ack=1
- dp_addr  in  8  datapath R[SA] (load/store address, jump target)
- dp_data  in  8  datapath R[SB] (store data)
- dp_z  in  1  datapath zero flag for R[SA]
- dp_n  in  1  datapath negative flag for R[SA]
- ir  out  16  current instruction register
- pc  out  8  current PC (address of the instruction being executed)
- ld_data  out  8  captured load data fed to the datapath MD mux
- rw_en  out  1  one-cycle register-file write strobe
- instr_done  out  1  one-cycle pulse when an instruction retires
- state  out  3  current FSM state (debug)

Behaviour:
- Reset values: pc=RESET_PC, ir=0, ld_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rw_en=0, instr_done=0, state=FETCH_HI.
- Reset is synchronous and overrides everything. A reset mid-transfer drops mem_req at that edge. An ack arriving in the reset cycle is ignored.
- Memory handshake:
  - While mem_req=1, mem_addr, mem_we and mem_wdata are stable.
  - Zero-wait ack is allowed: ack in the first req cycle completes at that edge.
  - mem_req deasserts for at least one cycle between transfers.
  - mem_ack while mem_req=0 is ignored.
- Instruction decode classes:
  - PL = IR[15]&IR[14]: branch/jump.
  - ST = ~IR[15]&IR[14]: store.
  - LD = ~IR[15]&~IR[14]&IR[13]: load.
  - Otherwise: ALU/immediate.
- FSM states:
  - FETCH_HI (0): req read at pc. On ack, ir[15:8] <= mem_rdata, then go to FETCH_LO.
  - FETCH_LO (1): idle one cycle, then req read at pc+1 (mod 256). On ack, ir[7:0] <= mem_rdata, then go to EXEC.
  - EXEC (2): one cycle, dispatching on class:
    - ALU: rw_en=1, instr_done=1, pc <= pc+2, go to FETCH_HI.
    - PL, IR[13]=1 (JMP): pc <= dp_addr & 8'hFE.
    - PL, IR[13]=0, IR[9]=0 (BRZ): taken if dp_z.
    - PL, IR[13]=0, IR[9]=1 (BRN): taken if dp_n.
    - Taken branch: pc <= pc + ({sext6(IR[8:6],IR[2:0])} << 1), mod 256.
    - Not-taken branch: pc <= pc+2.
    - All PL cases: rw_en=0, instr_done=1, go to FETCH_HI.
    - LD or ST: go to MEM.
  - MEM (3): req at dp_addr, sampled and held from MEM entry. ST: mem_we=1, mem_wdata=dp_data. LD: mem_we=0.
    - On ack, LD: ld_data <= mem_rdata, go to WB.
    - On ack, ST: instr_done=1, pc <= pc+2, go to FETCH_HI.
  - WB (4): rw_en=1, instr_done=1, pc <= pc+2, go to FETCH_HI.
- Latency in cycles with zero-wait memory:
  - ALU: 5 (FETCH_HI 1, gap 1, FETCH_LO 1... total 5).
  - Branch: 5.
  - Store: 6.
  - Load: 7.
- rw_en and instr_done are never high in FETCH_HI, FETCH_LO or MEM.
- PC wrap-around: 8'hFE + 2 = 8'h00. Fetching the low byte at 8'hFF is legal.
- States 5–7 are unreachable; if entered, go to FETCH_HI with no side effects.

Test Plan:
- Reset then zero-wait memory; mem[0]=8'h04, mem[1]=8'h4A (ALU ADD) -> requests at addresses 00 then 01; rw_en pulses once; pc=02; instr_done is 1 cycle.
- Ack delayed 3 cycles on each fetch -> mem_addr and mem_req stay stable throughout the wait; ir=16'h044A only after the second ack.
- LD with dp_addr=8'h80, mem[80]=8'h5C -> MEM reads 80; ld_data=5C; rw_en high in WB only; pc+=2.
- ST with dp_addr=8'h90, dp_data=8'hA5 -> mem_we=1 at address 90 with wdata A5; no rw_en; pc+=2.
- BRZ at pc=10, AD=6'b111110 (-2), dp_z=1 -> pc=0C; same instruction with dp_z=0 -> pc=12. JMP with dp_addr=8'h33 -> pc=32.
- Reset asserted while mem_req=1 and mem_ack=1 -> next cycle mem_req=0, pc=RESET_PC, ir unchanged at 0, state=FETCH_HI. pc=FE ALU -> pc wraps to 00.
